// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Scans six BCD digits from the clock/alarm core onto a 4-digit
//   common-anode 7-segment display. The digits, mode and page select are
//   captured once per scan frame so a frame never shows a mix of old and
//   new values. The field under edit can blink. Alarm mode is marked on
//   the decimal point of the rightmost digit.
//
//   Build option: define SEG7_BLINK_EN to build the blink counter and the
//   field blanking. Without it, pos, edit_en and BLINK_DIV have no effect
//   and every digit is always lit.
//
//   Parameters
//     REFRESH_DIV  clk cycles each digit stays lit (must be >= 2)
//     BLINK_DIV    clk cycles per blink half-period (blink build only)
//
//   Ports
//     clk                 system clock, rising edge
//     rst                 asynchronous active-high reset, blanks display
//     h2 h1 m2 m1 s2 s1   BCD digits (codes 10..15 show a dash)
//     pos                 edit cursor: 0 = minutes field, 1 = hours field
//     mode                0 = clock, 1 = alarm (forces HH:MM page, dp on digit 0)
//     edit_en             blinking of the field under the cursor enabled
//     show_sec            0 = HH:MM page, 1 = MM:SS page
//     seg                 segments {g,f,e,d,c,b,a}, active-low
//     dp                  decimal point, active-low
//     an                  anodes, active-low, an[0] is the rightmost digit
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h2,
    input  logic [3:0] h1,
    input  logic [3:0] m2,
    input  logic [3:0] m1,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    input  logic       pos,
    input  logic       mode,
    input  logic       edit_en,
    input  logic       show_sec,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [3:0] h2;
        logic [3:0] h1;
        logic [3:0] m2;
        logic [3:0] m1;
        logic [3:0] s2;
        logic [3:0] s1;
        logic       mode;
        logic       show_sec;
    } shadow_t;

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [1:0]        idx_q, idx_d;
    shadow_t           sh_q, sh_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              rcnt_wrap;
    logic              frame_start;
    logic              sec_page;
    logic              blank;
    logic [3:0]        cur_digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;  // dash for non-BCD codes
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Scan position and frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of an always_comb gets a value before any
        // branch; a path that leaves one unassigned infers a latch.
        rcnt_wrap   = (rcnt_q == RCNT_LAST);
        rcnt_d      = rcnt_wrap ? '0 : rcnt_q + RCNT_W'(1);
        idx_d       = rcnt_wrap ? idx_q + 2'd1 : idx_q;
        frame_start = (rcnt_q == '0) && (idx_q == 2'd0);
        sh_d        = sh_q;
        if (frame_start) begin
            sh_d = {h2, h1, m2, m1, s2, s1, mode, show_sec};
        end
    end

    // Alarm mode always shows the HH:MM page.
    assign sec_page = sh_q.show_sec & ~sh_q.mode;

    // ------------------------------------------------------------------
    // Blink phase and field blanking
    // ------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
    localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              blink_ph_q, blink_ph_d;
    logic              hours_here;
    logic              mins_here;

    always_comb begin
        bcnt_d     = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BCNT_W'(1);
        blink_ph_d = (bcnt_q == BCNT_LAST) ? ~blink_ph_q : blink_ph_q;
        // Hours sit on the two left places of the HH:MM page only; minutes
        // sit left on the MM:SS page and right on the HH:MM page.
        hours_here = ~sec_page & idx_q[1];
        mins_here  = sec_page ? idx_q[1] : ~idx_q[1];
        // Cursor and enable are taken live so the edit feedback is immediate.
        blank      = edit_en & blink_ph_q & (pos ? hours_here : mins_here);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q     <= '0;
            blink_ph_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            blink_ph_q <= blink_ph_d;
        end
    end
`else
    // pos, edit_en and BLINK_DIV have no function in this build; fold them
    // into explicitly unused names.
    localparam int unsigned unused_blink_div = BLINK_DIV;
    logic unused_blink_inputs;
    assign unused_blink_inputs = ^{pos, edit_en};
    assign blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Digit select, decode and output register
    // ------------------------------------------------------------------
    always_comb begin
        case (idx_q)
            2'd0:    cur_digit = sec_page ? sh_q.s1 : sh_q.m1;
            2'd1:    cur_digit = sec_page ? sh_q.s2 : sh_q.m2;
            2'd2:    cur_digit = sec_page ? sh_q.m1 : sh_q.h1;
            default: cur_digit = sec_page ? sh_q.m2 : sh_q.h2;
        endcase

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        // The edge that sees rcnt == 0 is the one on which idx or the
        // shadows have just changed; holding the drawing there keeps every
        // digit lit for exactly REFRESH_DIV cycles and makes the first
        // digit after reset appear one edge after the shadow load.
        if (rcnt_q != '0) begin
            if (blank) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = bcd_to_seg(cur_digit);
                // Colon substitute on idx 2; alarm marker on idx 0.
                dp_d  = ~((idx_q == 2'd2) | ((idx_q == 2'd0) & sh_q.mode));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow registers are reset like any other state so
            // nothing reads X before the first frame snapshot.
            rcnt_q <= '0;
            idx_q  <= 2'd0;
            sh_q   <= '0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            rcnt_q <= rcnt_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
